// File: rtl/ram_dma_arbiter.sv
// Single-port RAM/bus arbiter between the 65C02 core and one DMA requester.
// The CPU is stalled through cpu_rdy while the DMA side owns the port, then its held access is re-read.
module ram_dma_arbiter #(
  parameter int                 ADDR_W    = 16,
  parameter int                 DATA_W    = 8,
  parameter int                 MAX_BURST = 8,
  parameter logic [DATA_W-1:0]  NOP_BYTE  = 8'hEA
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_ab,
  input  logic [DATA_W-1:0] cpu_do,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_di,
  output logic              cpu_rdy,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_we,
  output logic              dma_gnt,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_CPU    = 2'd0,
    ST_DMA    = 2'd1,
    ST_RESUME = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    TAG_NONE   = 2'd0,
    TAG_CPU    = 2'd1,
    TAG_DMA_RD = 2'd2
  } tag_e;

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  state_e     state_q, state_d;
  tag_e       tag_q, tag_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic [7:0] burst_cnt_inc;
  logic       cpu_ran_q, cpu_ran_d;

  assign burst_cnt_inc = burst_cnt_q + 8'd1;

  // DMA handshake: the requester holds dma_req with a stable address/data/we
  // for each access; the access is performed in any cycle where dma_ack=1, and
  // the requester advances to its next access on the clock edge ending it.
  always_comb begin
    state_d     = state_q;
    tag_d       = TAG_NONE;
    burst_cnt_d = burst_cnt_q;
    cpu_ran_d   = cpu_ran_q;
    mem_addr    = cpu_ab;
    mem_wdata   = cpu_do;
    mem_we      = 1'b0;
    mem_en      = 1'b0;
    cpu_rdy     = 1'b0;
    dma_gnt     = 1'b0;
    dma_ack     = 1'b0;

    if (reset) begin
      // Look like an idle CPU read cycle so an aborted burst never writes.
      mem_en  = 1'b1;
      cpu_rdy = 1'b1;
    end else begin
      case (state_q)
        ST_CPU: begin
          mem_en    = 1'b1;
          mem_we    = cpu_we;
          cpu_rdy   = 1'b1;
          tag_d     = TAG_CPU;
          cpu_ran_d = 1'b1;
          if (dma_req && !cpu_we && cpu_ran_q) begin
            state_d     = ST_DMA;
            burst_cnt_d = 8'd0;
          end
        end
        ST_DMA: begin
          dma_gnt = 1'b1;
          if (dma_req) begin
            mem_addr    = dma_addr;
            mem_wdata   = dma_wdata;
            mem_we      = dma_we;
            mem_en      = 1'b1;
            dma_ack     = 1'b1;
            burst_cnt_d = burst_cnt_inc;
            tag_d       = dma_we ? TAG_NONE : TAG_DMA_RD;
            if (burst_cnt_inc == MAX_B) begin
              state_d = ST_RESUME;
            end
          end else begin
            state_d = ST_RESUME;
          end
        end
        ST_RESUME: begin
          // Pre-read the held CPU address so cpu_di is ready when rdy returns.
          mem_en    = 1'b1;
          tag_d     = TAG_CPU;
          cpu_ran_d = 1'b0;
          state_d   = ST_CPU;
        end
        default: begin
          state_d = ST_CPU;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CPU;
      tag_q       <= TAG_NONE;
      burst_cnt_q <= 8'd0;
      cpu_ran_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      burst_cnt_q <= burst_cnt_d;
      cpu_ran_q   <= cpu_ran_d;
    end
  end

  assign cpu_di     = (tag_q == TAG_CPU) ? mem_rdata : NOP_BYTE;
  assign dma_rvalid = (tag_q == TAG_DMA_RD);
  assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_ram_dma_arbiter.sv
// Directed bench for ram_dma_arbiter with a synchronous 64 KiB RAM model on the mem_* port.
module tb_ram_dma_arbiter;

  logic        clk;
  logic        reset;
  logic [15:0] cpu_ab;
  logic [7:0]  cpu_do;
  logic        cpu_we;
  logic [7:0]  cpu_di;
  logic        cpu_rdy;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_we;
  logic        dma_gnt;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic        dma_rvalid;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_en;
  logic [7:0]  mem_rdata;

  int n_checks = 0;
  int n_errors = 0;
  int wr8000_cnt = 0;

  logic [7:0] ram [0:65535];

  ram_dma_arbiter #(
    .ADDR_W(16), .DATA_W(8), .MAX_BURST(8), .NOP_BYTE(8'hEA)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we), .cpu_di(cpu_di), .cpu_rdy(cpu_rdy),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_we(dma_we),
    .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_en(mem_en),
    .mem_rdata(mem_rdata)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // synchronous RAM, read-before-write, 1-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_wdata;
    end
    if (mem_en && mem_we && mem_addr == 16'h8000) wr8000_cnt <= wr8000_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: apply one cycle of inputs at the falling edge, settle, return for checks
  task automatic cyc(input logic rst, input logic [15:0] ab, input logic [7:0] d, input logic we,
                     input logic req, input logic [15:0] da, input logic [7:0] dd, input logic dwe);
    @(negedge clk);
    reset     = rst;
    cpu_ab    = ab;
    cpu_do    = d;
    cpu_we    = we;
    dma_req   = req;
    dma_addr  = da;
    dma_wdata = dd;
    dma_we    = dwe;
    #1;
  endtask

  int k;
  int burst_idx;
  int acks;
  int gcyc;
  int gap;
  logic in_gnt;
  int b_acks [3];
  int b_gcyc [3];

  initial begin
    reset = 1'b1; cpu_ab = '0; cpu_do = '0; cpu_we = 1'b0;
    dma_req = 1'b0; dma_addr = '0; dma_wdata = '0; dma_we = 1'b0;

    // reset held with dma_req=1
    cyc(1, 16'h0000, 8'h00, 0, 1, 16'h0700, 8'h99, 1);
    check("rst0_rdy", cpu_rdy, 1);
    check("rst0_gnt", dma_gnt, 0);
    check("rst0_we", mem_we, 0);
    cyc(1, 16'h0000, 8'h00, 0, 1, 16'h0700, 8'h99, 1);
    check("rst1_rdy", cpu_rdy, 1);
    check("rst1_gnt", dma_gnt, 0);
    check("rst1_ack", dma_ack, 0);
    check("rst1_di_nop", cpu_di, 8'hEA);
    check("rst1_rvalid", dma_rvalid, 0);
    cyc(0, 16'h0000, 8'h00, 0, 1, 16'h0700, 8'h99, 1);
    check("post_rst_cpu_rdy", cpu_rdy, 1);
    check("post_rst_cpu_gnt", dma_gnt, 0);
    cyc(0, 16'h0000, 8'h00, 0, 1, 16'h0700, 8'h99, 1);
    check("first_gnt", dma_gnt, 1);
    check("first_ack", dma_ack, 1);
    check("first_rdy", cpu_rdy, 0);
    check("first_mem_we", mem_we, 1);
    check("first_mem_addr", mem_addr, 16'h0700);
    // dma_req drop costs one idle granted cycle with the port disabled
    cyc(0, 16'h0000, 8'h00, 0, 0, 16'h0700, 8'h99, 1);
    check("idle_gnt", dma_gnt, 1);
    check("idle_ack", dma_ack, 0);
    check("idle_en", mem_en, 0);
    check("idle_rvalid_wr", dma_rvalid, 0);
    cyc(0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
    check("resume1_rdy", cpu_rdy, 0);
    check("resume1_gnt", dma_gnt, 0);
    check("resume1_en", mem_en, 1);
    check("resume1_we", mem_we, 0);
    check("resume1_addr", mem_addr, 16'h0000);

    // preload RAM through CPU write cycles
    cyc(0, 16'h0200, 8'h5A, 1, 0, 16'h0000, 8'h00, 0);
    check("back_to_cpu_rdy", cpu_rdy, 1);
    check("ram_0700", ram[16'h0700], 8'h99);
    cyc(0, 16'h0201, 8'h3C, 1, 0, 16'h0000, 8'h00, 0);
    cyc(0, 16'h1234, 8'hC3, 1, 0, 16'h0000, 8'h00, 0);
    cyc(0, 16'h0601, 8'h77, 1, 0, 16'h0000, 8'h00, 0);
    cyc(0, 16'h0200, 8'h00, 0, 0, 16'h0000, 8'h00, 0);

    // CPU reading $0200 while DMA writes $0300..$0302
    cyc(0, 16'h0200, 8'h00, 0, 1, 16'h0300, 8'h11, 1);
    check("s2_cpu_rdy", cpu_rdy, 1);
    check("s2_cpu_addr", mem_addr, 16'h0200);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 16'h0200, 8'h00, 0, 1, 16'h0300 + 16'(i), 8'h11 * 8'(i + 1), 1);
      check("s2_gnt", dma_gnt, 1);
      check("s2_ack", dma_ack, 1);
      check("s2_rdy", cpu_rdy, 0);
      check("s2_addr", mem_addr, 16'h0300 + 16'(i));
    end
    cyc(0, 16'h0200, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
    check("s2_idle_gnt", dma_gnt, 1);
    check("s2_idle_rdy", cpu_rdy, 0);
    cyc(0, 16'h0200, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
    check("s2_resume_rdy", cpu_rdy, 0);
    check("s2_resume_addr", mem_addr, 16'h0200);
    cyc(0, 16'h0200, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
    check("s2_release_rdy", cpu_rdy, 1);
    check("s2_release_di", cpu_di, 8'h5A);
    check("s2_ram_0300", ram[16'h0300], 8'h11);
    check("s2_ram_0301", ram[16'h0301], 8'h22);
    check("s2_ram_0302", ram[16'h0302], 8'h33);

    // 20 held DMA writes split into bursts of 8, 8, 4
    k = 0; burst_idx = 0; acks = 0; gcyc = 0; gap = 0; in_gnt = 1'b0;
    for (int n = 0; n < 45; n++) begin
      cyc(0, 16'h0200, 8'h00, 0, (k < 20), 16'h0400 + 16'(k), 8'(k), 1);
      if (dma_gnt) begin
        if (!in_gnt) begin
          in_gnt = 1'b1; acks = 0; gcyc = 0;
          if (burst_idx > 0) check("s3_gap_rdy", 32'(gap >= 1), 1);
        end
        gcyc++;
        if (dma_ack) begin
          acks++;
          k++;
        end
      end else begin
        if (in_gnt) begin
          check("s3_resume_rdy", cpu_rdy, 0);
          if (burst_idx < 3) begin
            b_acks[burst_idx] = acks;
            b_gcyc[burst_idx] = gcyc;
          end
          burst_idx++;
          in_gnt = 1'b0;
          gap = 0;
        end else if (cpu_rdy) begin
          gap++;
        end
      end
    end
    check("s3_bursts", burst_idx, 3);
    check("s3_acks0", b_acks[0], 8);
    check("s3_acks1", b_acks[1], 8);
    check("s3_acks2", b_acks[2], 4);
    check("s3_gcyc0", b_gcyc[0], 8);
    check("s3_gcyc1", b_gcyc[1], 8);
    check("s3_gcyc2", b_gcyc[2], 5);
    for (int i = 0; i < 20; i++) check("s3_ram", ram[16'h0400 + 16'(i)], 8'(i));

    // dma_req rising during a CPU write to $8000
    cyc(0, 16'h8000, 8'hA5, 1, 1, 16'h1234, 8'h00, 0);
    check("s4_wr_gnt", dma_gnt, 0);
    check("s4_wr_rdy", cpu_rdy, 1);
    check("s4_wr_we", mem_we, 1);
    cyc(0, 16'h0201, 8'h00, 0, 1, 16'h1234, 8'h00, 0);
    check("s4_next_gnt", dma_gnt, 0);
    check("s4_next_rdy", cpu_rdy, 1);
    cyc(0, 16'h0201, 8'h00, 0, 1, 16'h1234, 8'h00, 0);
    check("s4_gnt", dma_gnt, 1);
    check("s4_ack", dma_ack, 1);
    check("s4_rd_we", mem_we, 0);
    cyc(0, 16'h0201, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
    check("s4_idle_rvalid", dma_rvalid, 1);
    check("s4_idle_rdata", dma_rdata, 8'hC3);
    cyc(0, 16'h0201, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
    check("s4_resume_rvalid", dma_rvalid, 0);
    check("s4_resume_addr", mem_addr, 16'h0201);
    cyc(0, 16'h0201, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
    check("s4_release_di", cpu_di, 8'h3C);
    check("s4_wr8000_cnt", wr8000_cnt, 1);
    check("s4_ram_8000", ram[16'h8000], 8'hA5);

    // full burst ending in a DMA read of $1234
    cyc(0, 16'h0200, 8'h00, 0, 1, 16'h0500, 8'hA0, 1);
    check("s5_cpu_gnt", dma_gnt, 0);
    for (int j = 0; j < 8; j++) begin
      cyc(0, 16'h0200, 8'h00, 0, 1, (j < 7) ? 16'h0500 + 16'(j) : 16'h1234,
          8'hA0 + 8'(j), (j < 7));
      check("s5_ack", dma_ack, 1);
    end
    cyc(0, 16'h0200, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
    check("s5_resume_rdy", cpu_rdy, 0);
    check("s5_resume_gnt", dma_gnt, 0);
    check("s5_resume_rvalid", dma_rvalid, 1);
    check("s5_resume_rdata", dma_rdata, 8'hC3);
    check("s5_resume_we", mem_we, 0);
    cyc(0, 16'h0200, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
    check("s5_release_rdy", cpu_rdy, 1);
    check("s5_release_rvalid", dma_rvalid, 0);
    check("s5_release_di", cpu_di, 8'h5A);
    check("s5_ram_0506", ram[16'h0506], 8'hA6);

    // reset in the second cycle of a write burst
    cyc(0, 16'h0200, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
    cyc(0, 16'h0200, 8'h00, 0, 1, 16'h0600, 8'hF0, 1);
    check("s6_cpu_gnt", dma_gnt, 0);
    cyc(0, 16'h0200, 8'h00, 0, 1, 16'h0600, 8'hF0, 1);
    check("s6_ack0", dma_ack, 1);
    cyc(1, 16'h0200, 8'h00, 0, 1, 16'h0601, 8'hF1, 1);
    check("s6_rst_we", mem_we, 0);
    check("s6_rst_gnt", dma_gnt, 0);
    check("s6_rst_ack", dma_ack, 0);
    check("s6_rst_rdy", cpu_rdy, 1);
    cyc(0, 16'h0200, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
    check("s6_after_rdy", cpu_rdy, 1);
    check("s6_after_gnt", dma_gnt, 0);
    check("s6_after_addr", mem_addr, 16'h0200);
    cyc(0, 16'h0200, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
    check("s6_ram_0600", ram[16'h0600], 8'hF0);
    check("s6_ram_0601", ram[16'h0601], 8'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
